// File: rtl/child_dispatch_rr.sv
// Round-robin dispatcher: buffers one upstream item and hands it to the next enabled child.
// Optional per-child delivery counters are built when DISPATCH_STATS_EN is defined.
module child_dispatch_rr #(
    parameter int NUM_CHILDREN = 10,
    parameter int DATA_W       = 16,
    parameter int CNT_W        = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [DATA_W-1:0]             in_data_i,
    input  logic [NUM_CHILDREN-1:0]       enable_mask_i,
    output logic [NUM_CHILDREN-1:0]       out_valid_o,
    input  logic [NUM_CHILDREN-1:0]       out_ready_i,
    output logic [DATA_W-1:0]             out_data_o,
    output logic                          idle_o,
    output logic [CNT_W-1:0]              dispatch_cnt_o,
    output logic [NUM_CHILDREN*CNT_W-1:0] child_cnt_o
);
    localparam int IDX_W = $clog2(NUM_CHILDREN);

    typedef enum logic [1:0] {IDLE, SELECT, OFFER} state_t;

    state_t                  state_q;
    logic [IDX_W-1:0]        ptr_q, tgt_q, pick;
    logic [DATA_W-1:0]       hold_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_CHILDREN-1:0] offer;
    logic                    any_en, hs;

    // Scan downward so the enabled child closest to ptr (in wrap order) wins.
    always_comb begin
        int idx;
        pick   = ptr_q;
        any_en = |enable_mask_i;
        for (int k = NUM_CHILDREN - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_CHILDREN) idx = idx - NUM_CHILDREN;
            if (enable_mask_i[IDX_W'(idx)]) pick = IDX_W'(idx);
        end
    end

    always_comb begin
        offer = '0;
        if (state_q == OFFER) offer[tgt_q] = 1'b1;
    end

    assign hs    = (state_q == OFFER) && out_ready_i[tgt_q];
    assign cnt_d = cnt_q + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            tgt_q   <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid_i) begin
                    hold_q  <= in_data_i;
                    state_q <= SELECT;
                end
                SELECT: if (any_en) begin
                    tgt_q   <= pick;
                    state_q <= OFFER;
                end
                OFFER: if (hs) begin
                    ptr_q   <= (tgt_q == IDX_W'(NUM_CHILDREN - 1)) ? '0 : tgt_q + 1'b1;
                    cnt_q   <= cnt_d;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // While rst is high every output is forced to its reset value.
    assign in_ready_o     = (state_q == IDLE) && !rst_i;
    assign idle_o         = rst_i || (state_q == IDLE);
    assign out_valid_o    = rst_i ? '0 : offer;
    assign out_data_o     = rst_i ? '0 : hold_q;
    assign dispatch_cnt_o = rst_i ? '0 : cnt_q;

`ifdef DISPATCH_STATS_EN
    logic [NUM_CHILDREN-1:0][CNT_W-1:0] ccnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)   ccnt_q        <= '0;
        else if (hs) ccnt_q[tgt_q] <= ccnt_q[tgt_q] + 1'b1;
    end

    assign child_cnt_o = rst_i ? '0 : ccnt_q;
`else
    assign child_cnt_o = '0;
`endif

endmodule

// File: tb/tb_child_dispatch_rr.sv
// Bench for child_dispatch_rr: item-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_child_dispatch_rr;
    localparam int N  = 10;
    localparam int DW = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, idle;
    logic [DW-1:0] in_data, out_data;
    logic [N-1:0]  mask, out_valid, out_ready;
    logic [CW-1:0] dcnt;
    logic [N*CW-1:0] ccnt;

    always #5 clk = ~clk;

    child_dispatch_rr #(.NUM_CHILDREN(N), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data), .enable_mask_i(mask), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_data_o(out_data), .idle_o(idle),
        .dispatch_cnt_o(dcnt), .child_cnt_o(ccnt)
    );

    int n_chk = 0, n_pass = 0, cyc = 0;

    // Reference model: one held item, its chosen child (-1 = not chosen yet), rotation pointer.
    bit            m_has;
    int            m_tgt, m_ptr;
    logic [DW-1:0] m_data;
    logic [CW-1:0] m_cnt;
    logic [CW-1:0] m_ccnt [N];
    int            dl_child[$], dl_cyc[$];
    logic [DW-1:0] dl_data[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic model_reset();
        m_has = 0; m_tgt = -1; m_ptr = 0; m_data = '0; m_cnt = '0;
        for (int i = 0; i < N; i++) m_ccnt[i] = '0;
    endtask

    // Compare at negedge, then advance the model by the upcoming posedge.
    task automatic tick();
        logic [N-1:0]    ev;
        logic [N*CW-1:0] ec;
        bit              found;
        @(negedge clk);
        ev = '0;
        ec = '0;
        if (!rst && m_tgt >= 0) ev[m_tgt] = 1'b1;
`ifdef DISPATCH_STATS_EN
        if (!rst) for (int i = 0; i < N; i++) ec[i*CW +: CW] = m_ccnt[i];
`endif
        chk("in_ready",  64'(in_ready),  64'(!rst && !m_has));
        chk("idle",      64'(idle),      64'(rst || !m_has));
        chk("out_valid", 64'(out_valid), 64'(ev));
        chk("out_data",  64'(out_data),  rst ? 64'(0) : 64'(m_data));
        chk("disp_cnt",  64'(dcnt),      rst ? 64'(0) : 64'(m_cnt));
        chk("child_cnt", 64'(ccnt),      64'(ec));
        if (rst) model_reset();
        else if (!m_has) begin
            if (in_valid) begin m_has = 1; m_data = in_data; m_tgt = -1; end
        end else if (m_tgt < 0) begin
            found = 0;
            for (int k = 0; k < N; k++)
                if (!found && mask[(m_ptr + k) % N]) begin found = 1; m_tgt = (m_ptr + k) % N; end
        end else if (out_ready[m_tgt]) begin
            dl_child.push_back(m_tgt); dl_cyc.push_back(cyc); dl_data.push_back(m_data);
            m_cnt = m_cnt + 1'b1;
            m_ccnt[m_tgt] = m_ccnt[m_tgt] + 1'b1;
            m_ptr = (m_tgt + 1) % N;
            m_has = 0; m_tgt = -1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    int exp2 [4] = '{2, 5, 2, 5};
    int k;
    logic [DW-1:0] snap;

    initial begin
        rst = 1; in_valid = 0; in_data = '0; mask = '1; out_ready = '0;
        model_reset();
        @(posedge clk); #1;
        repeat (3) tick();
        chk("rst_idle", 64'(idle), 64'(1));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        rst = 0;

        // 1: all enabled, all ready, back-to-back items
        out_ready = '1; in_valid = 1;
        repeat (30) begin in_data = DW'($urandom); tick(); end
        in_valid = 0;
        repeat (3) tick();
        chk("t1_count", 64'(dl_child.size()), 64'(10));
        for (int i = 0; i < dl_child.size() && i < 10; i++) chk("t1_order", 64'(dl_child[i]), 64'(i));
        for (int i = 1; i < dl_cyc.size(); i++) chk("t1_rate", 64'(dl_cyc[i] - dl_cyc[i-1]), 64'(3));
        chk("t1_dcnt", 64'(dcnt), 64'(10));

        // 2: sparse mask, pointer wraps past 9
        dl_child.delete(); dl_cyc.delete(); dl_data.delete();
        mask = 10'b0000100100; in_valid = 1;
        repeat (12) begin in_data = DW'($urandom); tick(); end
        in_valid = 0;
        repeat (3) tick();
        chk("t2_count", 64'(dl_child.size()), 64'(4));
        for (int i = 0; i < dl_child.size() && i < 4; i++) chk("t2_order", 64'(dl_child[i]), 64'(exp2[i]));

        // 3: no child enabled while an item is held
        mask = '0; in_valid = 1; in_data = 16'hBEEF;
        tick();
        in_valid = 0;
        repeat (20) tick();
        chk("t3_in_ready", 64'(in_ready), 64'(0));
        chk("t3_out_valid", 64'(out_valid), 64'(0));
        chk("t3_idle", 64'(idle), 64'(0));
        mask = 10'b0010000000;
        repeat (4) tick();
        chk("t3_count", 64'(dl_child.size()), 64'(5));
        chk("t3_child", 64'(dl_child[$]), 64'(7));
        chk("t3_data", 64'(dl_data[$]), 64'(16'hBEEF));

        // 4: target stalls 5 cycles, others ready
        mask = '1; out_ready = ~(10'b1 << 8); in_valid = 1; in_data = 16'h1234;
        tick();
        in_valid = 0; in_data = 16'h5555;
        k = 0;
        while (out_valid == 0 && k < 10) begin tick(); k++; end
        chk("t4_offer", 64'(out_valid), 64'(10'b1 << 8));
        snap = out_data;
        repeat (5) begin
            chk("t4_hold_v", 64'(out_valid), 64'(10'b1 << 8));
            chk("t4_hold_d", 64'(out_data), 64'(snap));
            tick();
        end
        chk("t4_not_yet", 64'(dl_child.size()), 64'(5));
        out_ready = '1;
        tick();
        chk("t4_count", 64'(dl_child.size()), 64'(6));
        chk("t4_child", 64'(dl_child[$]), 64'(8));
        chk("t4_data", 64'(dl_data[$]), 64'(16'h1234));

        // 5: reset during an offer discards the item
        out_ready = '0; in_valid = 1; in_data = 16'hDEAD;
        tick();
        in_valid = 0;
        k = 0;
        while (out_valid == 0 && k < 10) begin tick(); k++; end
        chk("t5_offer", 64'(out_valid != 0), 64'(1));
        rst = 1;
        tick();
        rst = 0;
        chk("t5_out_valid", 64'(out_valid), 64'(0));
        chk("t5_idle", 64'(idle), 64'(1));
        chk("t5_dcnt", 64'(dcnt), 64'(0));
        out_ready = '1;
        repeat (5) tick();
        chk("t5_dropped", 64'(dl_child.size()), 64'(6));

        // 6: 2^CW+3 items to child 0, counters wrap
        mask = 10'b1; in_valid = 1;
        repeat (3 * ((1 << CW) + 3)) begin in_data = DW'($urandom); tick(); end
        in_valid = 0;
        repeat (3) tick();
        chk("t6_count", 64'(dl_child.size()), 64'(6 + (1 << CW) + 3));
        chk("t6_dcnt", 64'(dcnt), 64'(3));
`ifdef DISPATCH_STATS_EN
        chk("t6_ccnt", 64'(ccnt), 64'(3));
`else
        chk("t6_ccnt", 64'(ccnt), 64'(0));
`endif

        // Randomized traffic, occasional resets
        repeat (3000) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = DW'($urandom);
            mask      = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
            out_ready = N'($urandom);
            rst       = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
